// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass, a per-register busy
// scoreboard for issue tracking, and a sequential clear of the array after reset.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*XLEN-1:0]   wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_addr,
    output logic                  iss_waw,
    input  logic                  flush
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   clr_ptr_reg;
    logic [AW-1:0]   clr_ptr_next;

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy_reg;

    // Per-address write resolution: which registers are written this cycle and
    // with what value after the highest-index port has won any collision.
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];

    logic active;

    // ------------------------------------------------------------------
    // Init / run sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= INIT;
            clr_ptr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        if (state_reg == INIT) begin
            clr_ptr_next = clr_ptr_reg + AW'(1);
            if (clr_ptr_reg == AW'(NREGS - 1)) begin
                state_next = RUN;
            end
        end
    end

    assign init_done = (state_reg == RUN);
    // Writes, issues, flushes and all read-side outputs only live in RUN with rst low.
    assign active    = (state_reg == RUN) && !rst;

    // ------------------------------------------------------------------
    // Write-port resolution (later ports override earlier ones)
    // ------------------------------------------------------------------
    always_comb begin
        wr_hit = '0;
        for (int a = 0; a < NREGS; a++) begin
            wr_val[a] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            if (active && we[j] && (waddr[j*AW +: AW] != '0)) begin
                wr_hit[waddr[j*AW +: AW]] = 1'b1;
                wr_val[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register array: one cleared entry per INIT cycle, resolved writes in RUN
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT) begin
                regs[clr_ptr_reg] <= '0;
            end else begin
                for (int a = 1; a < NREGS; a++) begin
                    if (wr_hit[a]) begin
                        regs[a] <= wr_val[a];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard. A new issue outranks a same-cycle writeback because the
    // writeback belongs to the older producer of that register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else if (active) begin
            if (flush) begin
                busy_reg <= '0;
            end else begin
                for (int a = 1; a < NREGS; a++) begin
                    if (iss_valid && (iss_addr == AW'(a))) begin
                        busy_reg[a] <= 1'b1;
                    end else if (wr_hit[a]) begin
                        busy_reg[a] <= 1'b0;
                    end
                end
            end
        end
    end

    assign iss_waw = active && iss_valid && (iss_addr != '0) && busy_reg[iss_addr];

    // ------------------------------------------------------------------
    // Read ports with bypass; a bypassed operand is never reported busy
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] ra;
            logic          sel;

            assign ra  = raddr[gi*AW +: AW];
            assign sel = active && re[gi] && (ra != '0);

            assign rdata[gi*XLEN +: XLEN] = !sel       ? '0
                                          : wr_hit[ra] ? wr_val[ra]
                                          :              regs[ra];
            assign rbusy[gi] = sel && busy_reg[ra] && !wr_hit[ra];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural model of
// the register contents, busy bits and init countdown.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 init_done;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*XLEN-1:0]  wdata;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rbusy;
    logic                 iss_valid;
    logic [AW-1:0]        iss_addr;
    logic                 iss_waw;
    logic                 flush;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_waw(iss_waw),
        .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference state: cycles since reset, architectural contents, busy flags.
    int              m_cnt;
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        re = '0; raddr = '0;
        iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic set_w(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we[j] = 1'b1;
        waddr[j*AW +: AW] = a;
        wdata[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_r(input int k, input logic [AW-1:0] a);
        re[k] = 1'b1;
        raddr[k*AW +: AW] = a;
    endtask

    function automatic logic [XLEN-1:0] rd(input int k);
        return rdata[k*XLEN +: XLEN];
    endfunction

    task automatic model_check();
        bit run;
        run = (m_cnt >= NREGS);
        check("init_done", init_done, run);
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] exp_d;
            bit              exp_b;
            bit              hit;
            a = raddr[k*AW +: AW];
            exp_d = '0;
            exp_b = 0;
            hit = 0;
            if (!rst && run && re[k] && a != 0) begin
                exp_d = m_regs[a];
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && waddr[j*AW +: AW] == a) begin
                        exp_d = wdata[j*XLEN +: XLEN];
                        hit = 1;
                    end
                end
                exp_b = m_busy[a] && !hit;
            end
            check($sformatf("rdata%0d", k), rd(k), exp_d);
            check($sformatf("rbusy%0d", k), rbusy[k], exp_b);
        end
        check("iss_waw", iss_waw,
              !rst && run && iss_valid && iss_addr != 0 && m_busy[iss_addr]);
    endtask

    task automatic model_update();
        if (rst) begin
            m_cnt = 0;
            for (int a = 0; a < NREGS; a++) begin
                m_regs[a] = '0;
                m_busy[a] = 0;
            end
        end else if (m_cnt < NREGS) begin
            m_cnt++;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && waddr[j*AW +: AW] != 0) begin
                    m_regs[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
                    m_busy[waddr[j*AW +: AW]] = 0;
                end
            end
            if (flush) begin
                for (int a = 0; a < NREGS; a++) m_busy[a] = 0;
            end else if (iss_valid && iss_addr != 0) begin
                m_busy[iss_addr] = 1;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        advance();
        rst = 1'b0;

        // Init countdown; a write during INIT must be lost.
        for (int c = 0; c <= NREGS; c++) begin
            idle();
            set_r(0, (c == NREGS) ? AW'(5) : AW'($urandom_range(0, NREGS - 1)));
            set_r(1, AW'($urandom_range(0, NREGS - 1)));
            if (c == 3) set_w(0, 5'd5, 32'hDEAD);
            sample();
            check("init_done_lit", init_done, (c >= NREGS));
            if (c == NREGS) check("x5_after_init", rd(0), 32'h0);
            advance();
        end

        // Write collision: highest port wins, both bypassed and stored.
        idle();
        set_w(0, 5'd3, 32'h11111111);
        set_w(1, 5'd3, 32'h22222222);
        set_r(0, 5'd3);
        sample();
        check("x3_bypass", rd(0), 32'h22222222);
        advance();
        idle();
        set_r(0, 5'd3);
        sample();
        check("x3_array", rd(0), 32'h22222222);
        advance();

        // Register zero is immutable and never busy.
        idle();
        set_w(0, 5'd0, 32'hFFFFFFFF);
        set_r(0, 5'd0);
        set_r(1, 5'd0);
        iss_valid = 1'b1;
        iss_addr = 5'd0;
        sample();
        check("x0_rd0", rd(0), 32'h0);
        check("x0_rd1", rd(1), 32'h0);
        check("x0_waw", iss_waw, 1'b0);
        advance();
        idle();
        iss_valid = 1'b1;
        iss_addr = 5'd0;
        set_r(0, 5'd0);
        sample();
        check("x0_waw2", iss_waw, 1'b0);
        advance();

        // Issue then writeback on x7.
        idle();
        iss_valid = 1'b1;
        iss_addr = 5'd7;
        sample();
        advance();
        idle();
        set_r(0, 5'd7);
        sample();
        check("x7_busy", rbusy[0], 1'b1);
        advance();
        idle();
        set_w(1, 5'd7, 32'h55);
        set_r(0, 5'd7);
        sample();
        check("x7_bypass_busy", rbusy[0], 1'b0);
        check("x7_bypass_data", rd(0), 32'h55);
        advance();
        idle();
        set_r(0, 5'd7);
        sample();
        check("x7_array_busy", rbusy[0], 1'b0);
        check("x7_array_data", rd(0), 32'h55);
        advance();

        // Issue beats same-cycle writeback; WAW flag; flush clears.
        idle();
        iss_valid = 1'b1;
        iss_addr = 5'd9;
        set_w(0, 5'd9, 32'h99);
        sample();
        advance();
        idle();
        set_r(1, 5'd9);
        iss_valid = 1'b1;
        iss_addr = 5'd9;
        sample();
        check("x9_busy", rbusy[1], 1'b1);
        check("x9_waw", iss_waw, 1'b1);
        check("x9_data", rd(1), 32'h99);
        advance();
        idle();
        flush = 1'b1;
        sample();
        advance();
        idle();
        set_r(1, 5'd9);
        sample();
        check("x9_flushed", rbusy[1], 1'b0);
        advance();

        // Mid-RUN reset re-zeroes the array.
        idle();
        set_w(0, 5'd4, 32'h1234);
        sample();
        advance();
        idle();
        set_r(0, 5'd4);
        sample();
        check("x4_written", rd(0), 32'h1234);
        advance();
        idle();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        for (int c = 0; c <= NREGS; c++) begin
            idle();
            set_r(0, 5'd4);
            sample();
            check("reinit_done", init_done, (c >= NREGS));
            if (c == NREGS) check("x4_cleared", rd(0), 32'h0);
            advance();
        end

        // Random traffic on a narrow address window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 399) == 0);
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) == 1)
                    set_w(j, AW'($urandom_range(0, 7)), $urandom);
            end
            for (int k = 0; k < NRD; k++) begin
                if ($urandom_range(0, 3) != 0) set_r(k, AW'($urandom_range(0, 7)));
                else raddr[k*AW +: AW] = AW'($urandom_range(0, 7));
            end
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, 7));
            flush = ($urandom_range(0, 24) == 0);
            sample();
            advance();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard and a sequential post-reset clear. It is the next generation of the pipeline's two-read/one-write register file. It adds configurable width, depth and read/write port counts, ordered write-port collision resolution, and same-cycle write-to-read bypass on every port. It sits between decode (reads, issue marking) and writeback (writes) in the multi-issue core.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of registers (power of two, ≥ 2); register 0 is hard-wired zero
- AW, 5, address width, equal to log2(NREGS)
- NRD, 2, number of read ports
- NWR, 2, number of write ports

Ports (clock and reset first; multi-port buses are flattened, port k occupies slice [k*W +: W]):
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once post-reset clear has completed
- we  in  NWR  write enable per write port
- waddr  in  NWR*AW  write address per port
- wdata  in  NWR*XLEN  write data per port
- re  in  NRD  read enable per read port
- raddr  in  NRD*AW  read address per port
- rdata  out  NRD*XLEN  read data per port (combinational)
- rbusy  out  NRD  read operand has a pending producer (combinational)
- iss_valid  in  1  mark iss_addr busy (new producer issued)
- iss_addr  in  AW  register being marked busy
- iss_waw  out  1  iss_valid and iss_addr already busy (combinational)
- flush  in  1  clear all busy bits

## Operation
- States: INIT, RUN. rst high forces INIT, clr_ptr=0, init_done=0, all busy bits 0.
- INIT: each cycle, write zero to regs[clr_ptr] and increment clr_ptr. After the cycle that clears NREGS-1, enter RUN. While in INIT:
  - we, iss_valid and flush are ignored.
  - rdata=0, rbusy=0, iss_waw=0.
- RUN: init_done=1. RUN is left only via rst.
- Write: port j updates regs[waddr_j] when we_j and waddr_j≠0. If several ports hit the same address, the highest-index port wins. Writes to address 0 are discarded.
- Read port k, evaluated in priority order:
  - rst or INIT → 0
  - else re_k=0 → 0
  - else raddr_k=0 → 0
  - else any we_j with waddr_j==raddr_k → wdata of the highest such j (bypass)
  - else regs[raddr_k]
- Busy scoreboard, next-state per address a≠0, in priority order:
  - flush → 0
  - else iss_valid and iss_addr==a → 1. Set wins over a same-cycle write to a, because the write belongs to the older producer.
  - else any write hits a → 0
  - else hold.
- busy[0] is always 0. Issue of address 0 is ignored.
- rbusy_k = re_k & raddr_k≠0 & busy[raddr_k] & no write port hits raddr_k this cycle. A bypassed operand is never reported busy.
- iss_waw = iss_valid & iss_addr≠0 & busy[iss_addr]. This is advisory only; the issue marking still occurs.

## Timing
- Reset values: init_done=0, rdata=0, rbusy=0, iss_waw=0, busy=0.
- init_done rises at the NREGS-th rising edge after the first edge with rst low, and is visible in cycle NREGS.
- Write latency: a written value is visible via bypass in the same cycle, and from the array from the next cycle.
- Busy latency: a set or clear takes effect from the next cycle. A same-cycle write clearing is seen on rbusy through the bypass term.
- rst asserted mid-INIT or mid-RUN: the next edge returns to INIT with clr_ptr=0 and init_done=0. Register contents are re-zeroed over the following NREGS cycles.
- rdata, rbusy and iss_waw are purely combinational from current inputs and state. There are no read-port registers.

## Test plan
- Reset then idle with NREGS=32 → init_done=0 for cycles 0–31 and 1 at cycle 32; reads of all addresses return 0. A we=1 to x5 with 0xDEAD during INIT is dropped, and a later read of x5 returns 0.
- Port0 writes x3=0x11111111 while port1 writes x3=0x22222222 in the same cycle; read x3 same cycle and next cycle → 0x22222222 both times.
- Write x0=0xFFFFFFFF and read x0 on both ports → 0. iss_valid on x0 → busy unchanged, iss_waw=0.
- Issue x7, then next cycle read x7 → rbusy=1. Write x7=0x55 the cycle after → rbusy=0 that cycle with rdata=0x55 (bypass); the following cycle rbusy=0 and rdata=0x55 from the array.
- Issue x9 and write x9 in the same cycle → next cycle rbusy(x9)=1. Issue x9 again → iss_waw=1. Assert flush → next cycle rbusy(x9)=0.
- In RUN with x4=0x1234, assert rst for 1 cycle → init_done=0 for 32 cycles, and a read of x4 after init_done returns 0.
